// File: rtl/lcd_serial_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lcd_serial_rx
//   Receiver for a PCD8544-style LCD serial interface. SCLK/SDIN/DnC/nSCE/nRES
//   arrive asynchronously. They are brought into the Clock domain and
//   assembled MSB first into bytes. Command bytes update the function-set
//   bits and the X/Y pointers. Data bytes produce a frame-memory write and
//   advance the pointers, either horizontally or vertically.
//
//   Optional feature: define LCD_SERIAL_RX_FRAME_ERR_EN to enable framing-error
//   detection. With the macro defined, frame_err is set when nSCE is released
//   mid-byte. Without the macro, frame_err is tied to 0.
//
// Ports
//   Clock, nReset        system clock, async active-low reset
//   SCLK, SDIN, DnC      serial clock / data / data-not-command (async inputs)
//   nSCE, nRES           chip enable and display reset, active low (async)
//   byte_valid           1-cycle strobe for each complete byte
//   byte_data, byte_dnc  last byte and its DnC value
//   wr_en, wr_addr,      1-cycle frame-memory write, address Y*COLS+X,
//   wr_data              and the byte to write
//   x_addr, y_addr       current column / bank pointers
//   h_mode, v_mode, pd   function-set bits H, V, PD
//   frame_err            sticky framing error
// ---------------------------------------------------------------------------
module lcd_serial_rx #(
  parameter int COLS  = 84,
  parameter int BANKS = 6
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       SCLK,
  input  logic       SDIN,
  input  logic       DnC,
  input  logic       nSCE,
  input  logic       nRES,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dnc,
  output logic       wr_en,
  output logic [8:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [6:0] x_addr,
  output logic [2:0] y_addr,
  output logic       h_mode,
  output logic       v_mode,
  output logic       pd,
  output logic       frame_err
);

  localparam logic [6:0] COLS_M1  = 7'(COLS - 1);
  localparam logic [2:0] BANKS_M1 = 3'(BANKS - 1);
  localparam logic [8:0] COLS_W   = 9'(COLS);

  // Two-flop synchronizers; bit [1] is the synchronized copy.
  logic [1:0] sclk_sync_q, sdin_sync_q, dnc_sync_q, nsce_sync_q, nres_sync_q;
  logic       sclk_prev_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sclk_sync_q <= 2'b00;
      sdin_sync_q <= 2'b00;
      dnc_sync_q  <= 2'b00;
      nsce_sync_q <= 2'b11;
      nres_sync_q <= 2'b11;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], SCLK};
      sdin_sync_q <= {sdin_sync_q[0], SDIN};
      dnc_sync_q  <= {dnc_sync_q[0],  DnC};
      nsce_sync_q <= {nsce_sync_q[0], nSCE};
      nres_sync_q <= {nres_sync_q[0], nRES};
      // The edge detector keeps tracking through nRES, so a high SCLK at
      // release does not look like a fresh rising edge.
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  logic sclk_s, sdin_s, dnc_s, nsce_s, nres_s;
  assign sclk_s = sclk_sync_q[1];
  assign sdin_s = sdin_sync_q[1];
  assign dnc_s  = dnc_sync_q[1];
  assign nsce_s = nsce_sync_q[1];
  assign nres_s = nres_sync_q[1];

  // Receiver / decoder state
  logic [7:0] shift_q,   shift_d;
  logic [2:0] bitcnt_q,  bitcnt_d;
  logic       bv_q,      bv_d;
  logic [7:0] bdata_q,   bdata_d;
  logic       bdnc_q,    bdnc_d;
  logic       wren_q,    wren_d;
  logic [8:0] waddr_q,   waddr_d;
  logic [7:0] wdata_q,   wdata_d;
  logic [6:0] x_q,       x_d;
  logic [2:0] y_q,       y_d;
  logic       h_q,       h_d;
  logic       v_q,       v_d;
  logic       pd_q,      pd_d;

  logic       shift_en, byte_done;
  logic [7:0] byte_full;
  logic [8:0] lin_addr;

  assign shift_en  = sclk_s & ~sclk_prev_q & ~nsce_s;
  assign byte_done = shift_en & (bitcnt_q == 3'd7);
  assign byte_full = {shift_q[6:0], sdin_s};
  assign lin_addr  = {6'd0, y_q} * COLS_W + {2'd0, x_q};

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    bv_d     = 1'b0;
    bdata_d  = bdata_q;
    bdnc_d   = bdnc_q;
    wren_d   = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    x_d      = x_q;
    y_d      = y_q;
    h_d      = h_q;
    v_d      = v_q;
    pd_d     = pd_q;

    // A deselected chip drops any partial byte.
    if (nsce_s) begin
      shift_d  = 8'd0;
      bitcnt_d = 3'd0;
    end else if (shift_en) begin
      shift_d  = byte_full;
      bitcnt_d = bitcnt_q + 3'd1;
    end

    if (byte_done) begin
      bv_d    = 1'b1;
      bdata_d = byte_full;
      bdnc_d  = dnc_s;
      if (dnc_s) begin
        // The write uses the pointers as they were before this byte.
        wren_d  = 1'b1;
        waddr_d = lin_addr;
        wdata_d = byte_full;
        if (!v_q) begin
          if (x_q == COLS_M1) begin
            x_d = 7'd0;
            y_d = (y_q == BANKS_M1) ? 3'd0 : y_q + 3'd1;
          end else begin
            x_d = x_q + 7'd1;
          end
        end else begin
          if (y_q == BANKS_M1) begin
            y_d = 3'd0;
            x_d = (x_q == COLS_M1) ? 7'd0 : x_q + 7'd1;
          end else begin
            y_d = y_q + 3'd1;
          end
        end
      end else if (byte_full[7:3] == 5'b00100) begin
        // The function set is decoded in both instruction sets.
        pd_d = byte_full[2];
        v_d  = byte_full[1];
        h_d  = byte_full[0];
      end else if (!h_q) begin
        if (byte_full[7]) begin
          if (byte_full[6:0] <= COLS_M1) x_d = byte_full[6:0];
        end else if (byte_full[7:3] == 5'b01000) begin
          if (byte_full[2:0] <= BANKS_M1) y_d = byte_full[2:0];
        end
      end
    end

    // The display reset clears everything downstream of the synchronizers.
    if (!nres_s) begin
      shift_d  = 8'd0;
      bitcnt_d = 3'd0;
      bv_d     = 1'b0;
      bdata_d  = 8'd0;
      bdnc_d   = 1'b0;
      wren_d   = 1'b0;
      waddr_d  = 9'd0;
      wdata_d  = 8'd0;
      x_d      = 7'd0;
      y_d      = 3'd0;
      h_d      = 1'b0;
      v_d      = 1'b0;
      pd_d     = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      shift_q  <= 8'd0;
      bitcnt_q <= 3'd0;
      bv_q     <= 1'b0;
      bdata_q  <= 8'd0;
      bdnc_q   <= 1'b0;
      wren_q   <= 1'b0;
      waddr_q  <= 9'd0;
      wdata_q  <= 8'd0;
      x_q      <= 7'd0;
      y_q      <= 3'd0;
      h_q      <= 1'b0;
      v_q      <= 1'b0;
      pd_q     <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      bv_q     <= bv_d;
      bdata_q  <= bdata_d;
      bdnc_q   <= bdnc_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      x_q      <= x_d;
      y_q      <= y_d;
      h_q      <= h_d;
      v_q      <= v_d;
      pd_q     <= pd_d;
    end
  end

`ifdef LCD_SERIAL_RX_FRAME_ERR_EN
  // Releasing nSCE with a partial byte in the shifter is a framing error.
  logic nsce_prev_q;
  logic fe_q, fe_d;

  always_comb begin
    fe_d = fe_q;
    if (!nres_s)
      fe_d = 1'b0;
    else if (nsce_s && !nsce_prev_q && (bitcnt_q != 3'd0))
      fe_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      nsce_prev_q <= 1'b1;
      fe_q        <= 1'b0;
    end else begin
      nsce_prev_q <= nsce_s;
      fe_q        <= fe_d;
    end
  end

  assign frame_err = fe_q;
`else
  assign frame_err = 1'b0;
`endif

  assign byte_valid = bv_q;
  assign byte_data  = bdata_q;
  assign byte_dnc   = bdnc_q;
  assign wr_en      = wren_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;
  assign x_addr     = x_q;
  assign y_addr     = y_q;
  assign h_mode     = h_q;
  assign v_mode     = v_q;
  assign pd         = pd_q;

endmodule
